// File: rtl/smag_pkg.sv
// Shared definitions for the sign-magnitude accumulator slice: FSM state
// encoding and the symmetric saturation limit.
package smag_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Largest magnitude a two's complement accumulator of acc_w bits may hold
  // when clamped symmetrically, so its magnitude always fits in acc_w-1 bits.
  function automatic int sat_limit(input int acc_w);
    return (1 << (acc_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/smag_to_twos.sv
// Combinational decode of a sign-magnitude value into two's complement.
// A negative zero decodes to plain zero.
module smag_to_twos #(
  parameter int W = 4
) (
  input  logic                sign,
  input  logic [W-1:0]        mag,
  output logic signed [W:0]   value
);

  logic signed [W:0] pos;

  assign pos = $signed({1'b0, mag});

  // Negate the zero-extended magnitude when the sign bit is set.
  always_comb begin
    value = sign ? -pos : pos;
  end

endmodule

// File: rtl/smag_accumulator.sv
// Accumulates a burst of sign-magnitude samples into a symmetric saturating
// two's complement total and presents the result as sign-magnitude on a
// valid/ready output.
module smag_accumulator #(
  parameter int MAG_W   = 4,
  parameter int ACC_W   = 8,
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sign,
  input  logic [MAG_W-1:0]   in_mag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign,
  output logic [ACC_W-2:0]   out_mag,
  output logic               out_sat,
  output logic               busy
);

  import smag_pkg::*;

  localparam int                SAT_LIM = sat_limit(ACC_W);
  localparam logic signed [ACC_W:0] SAT_POS = SAT_LIM[ACC_W:0];
  localparam logic signed [ACC_W:0] SAT_NEG = -SAT_POS;

  logic [1:0]               state;
  logic [1:0]               state_next;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;
  logic [COUNT_W-1:0]       cnt;
  logic                     sat;
  logic                     beat;
  logic                     last_beat;
  logic signed [MAG_W:0]    sample;
  logic signed [ACC_W:0]    sample_ext;
  logic signed [ACC_W:0]    sum;
  logic                     clamp;
  logic                     res_neg;
  logic [ACC_W-1:0]         res_abs;

  smag_to_twos #(.W(MAG_W)) u_in_decode (
    .sign  (in_sign),
    .mag   (in_mag),
    .value (sample)
  );

  assign beat       = in_valid & in_ready;
  assign last_beat  = beat && (cnt == COUNT_W'(1));
  assign sample_ext = (ACC_W+1)'(sample);
  // One guard bit above the accumulator so the raw sum can never wrap.
  assign sum        = $signed({acc[ACC_W-1], acc}) + sample_ext;

  // Clamp the widened sum back into the symmetric range.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    acc_next = sum[ACC_W-1:0];
    clamp    = 1'b0;
    if (sum > SAT_POS) begin
      acc_next = SAT_POS[ACC_W-1:0];
      clamp    = 1'b1;
    end else if (sum < SAT_NEG) begin
      acc_next = SAT_NEG[ACC_W-1:0];
      clamp    = 1'b1;
    end
  end

  // Re-encode the post-beat total as sign and magnitude; zero is always positive.
  always_comb begin
    res_neg = acc_next[ACC_W-1];
    res_abs = res_neg ? -acc_next : acc_next;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (len == '0) ? DONE : ACC;
      ACC:     if (last_beat) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Only in_ready is a direct decode of the current state.
  always_comb begin
    in_ready = (state == ACC);
  end

  // Registered status flags, loaded from the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= (state_next == DONE);
      busy      <= (state_next != IDLE);
    end
  end

  // Accumulator, beat counter, sticky saturation flag and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      sat      <= 1'b0;
      out_sign <= 1'b0;
      out_mag  <= '0;
      out_sat  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            cnt <= len;
            sat <= 1'b0;
            if (len == '0) begin
              out_sign <= 1'b0;
              out_mag  <= '0;
              out_sat  <= 1'b0;
            end
          end
        end
        ACC: begin
          if (beat) begin
            acc <= acc_next;
            cnt <= cnt - COUNT_W'(1);
            sat <= sat | clamp;
            if (last_beat) begin
              out_sign <= res_neg;
              out_mag  <= res_abs[ACC_W-2:0];
              out_sat  <= sat | clamp;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_smag_accumulator.sv
// Self-checking bench for smag_accumulator: directed vector table, hand-written
// handshake and reset sequences, and randomized bursts against a reference model.
module tb_smag_accumulator;

  localparam int MAG_W   = 4;
  localparam int ACC_W   = 8;
  localparam int COUNT_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [COUNT_W-1:0] len;
  logic               in_valid;
  logic               in_ready;
  logic               in_sign;
  logic [MAG_W-1:0]   in_mag;
  logic               out_valid;
  logic               out_ready;
  logic               out_sign;
  logic [ACC_W-2:0]   out_mag;
  logic               out_sat;
  logic               busy;

  int errors = 0;
  int checks = 0;

  int b_sgn [16];
  int b_mag [16];

  typedef struct {
    string name;
    int    len;
    int    sgn [16];
    int    mag [16];
    int    e_sign;
    int    e_mag;
    int    e_sat;
  } vec_t;

  vec_t vecs [$];

  smag_accumulator #(.MAG_W(MAG_W), .ACC_W(ACC_W), .COUNT_W(COUNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_mag    (in_mag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_mag   (out_mag),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: signed sum of the burst, clamped to +/-(2**(ACC_W-1)-1) after each beat.
  task automatic model(input int n, output int es, output int em, output int esat);
    int lim;
    int total;
    lim   = (2 ** (ACC_W - 1)) - 1;
    total = 0;
    esat  = 0;
    for (int i = 0; i < n; i++) begin
      total += (b_sgn[i] != 0) ? -b_mag[i] : b_mag[i];
      if (total > lim)  begin total = lim;  esat = 1; end
      if (total < -lim) begin total = -lim; esat = 1; end
    end
    es = (total < 0) ? 1 : 0;
    em = (total < 0) ? -total : total;
  endtask

  function automatic vec_t mk(input string name, input int n, input int s, input int m,
                              input int es, input int em, input int esat);
    vec_t v;
    v.name = name;
    v.len  = n;
    for (int i = 0; i < 16; i++) begin
      v.sgn[i] = s;
      v.mag[i] = m;
    end
    v.e_sign = es;
    v.e_mag  = em;
    v.e_sat  = esat;
    return v;
  endfunction

  // Runs one burst from IDLE using b_sgn/b_mag, then checks latency, result,
  // stability while out_ready is low, and the handshake back to IDLE.
  task automatic do_burst(input int n, input int gap_max, input int hold,
                          input int es, input int em, input int esat, input string tag);
    int budget;
    int gap;
    start = 1'b1;
    len   = COUNT_W'(n);
    @(negedge clk);
    start = 1'b0;
    check({tag, ".busy"}, 32'(busy), 1);
    for (int i = 0; i < n; i++) begin
      gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (gap) begin
        in_valid = 1'b0;
        in_sign  = 1'($urandom);
        in_mag   = MAG_W'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_sign  = 1'(b_sgn[i]);
      in_mag   = MAG_W'(b_mag[i]);
      budget = 0;
      while (!in_ready && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      check({tag, ".in_ready"}, 32'(in_ready), 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check({tag, ".out_valid_latency"}, 32'(out_valid), 1);
    check({tag, ".in_ready_done"}, 32'(in_ready), 0);
    check({tag, ".out_sign"}, 32'(out_sign), 32'(es));
    check({tag, ".out_mag"}, 32'(out_mag), 32'(em));
    check({tag, ".out_sat"}, 32'(out_sat), 32'(esat));
    repeat (hold) begin
      out_ready = 1'b0;
      @(negedge clk);
      check({tag, ".hold_valid"}, 32'(out_valid), 1);
      check({tag, ".hold_mag"}, 32'(out_mag), 32'(em));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".valid_drop"}, 32'(out_valid), 0);
    check({tag, ".busy_idle"}, 32'(busy), 0);
  endtask

  initial begin
    vec_t v;
    int es;
    int em;
    int esat;
    int n;

    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_sign = 1'b0;
    in_mag = '0; out_ready = 1'b0;

    // Directed vectors.
    v = mk("t1_mixed", 3, 0, 0, 0, 9, 0);
    v.mag[0] = 5; v.sgn[1] = 1; v.mag[1] = 3; v.mag[2] = 7;
    vecs.push_back(v);
    vecs.push_back(mk("t2_neg", 2, 1, 15, 1, 30, 0));
    vecs.push_back(mk("t3_possat", 10, 0, 15, 0, 127, 1));
    vecs.push_back(mk("t3_after_sat", 1, 1, 4, 1, 4, 0));
    vecs.push_back(mk("t4_negzero", 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("t4_len0", 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("negsat", 10, 1, 15, 1, 127, 1));
    v = mk("exact_limit", 9, 0, 15, 0, 127, 0);
    v.mag[8] = 7;
    vecs.push_back(v);
    v = mk("sat_recover", 10, 0, 15, 0, 112, 1);
    v.sgn[9] = 1;
    vecs.push_back(v);

    // Reset state.
    #2;
    check("reset.out_valid", 32'(out_valid), 0);
    check("reset.busy", 32'(busy), 0);
    check("reset.in_ready", 32'(in_ready), 0);
    check("reset.out_mag", 32'(out_mag), 0);
    check("reset.out_sign", 32'(out_sign), 0);
    check("reset.out_sat", 32'(out_sat), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[k]) begin
      for (int i = 0; i < 16; i++) begin
        b_sgn[i] = vecs[k].sgn[i];
        b_mag[i] = vecs[k].mag[i];
      end
      do_burst(vecs[k].len, 1, 1, vecs[k].e_sign, vecs[k].e_mag, vecs[k].e_sat, vecs[k].name);
    end

    // len=0 with in_valid held high: no beat consumed, zero result.
    in_valid = 1'b1; in_sign = 1'b0; in_mag = 4'd5;
    start = 1'b1; len = '0;
    @(negedge clk);
    start = 1'b0;
    check("len0.out_valid", 32'(out_valid), 1);
    check("len0.in_ready", 32'(in_ready), 0);
    check("len0.out_mag", 32'(out_mag), 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    check("len0.valid_drop", 32'(out_valid), 0);

    // Gaps, start pulses in ACC and DONE, out_ready low for 5 clocks.
    start = 1'b1; len = 4'd3;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_sign = 1'b0; in_mag = 4'd1;
    @(negedge clk);
    in_valid = 1'b0; start = 1'b1; len = 4'd7;
    @(negedge clk);
    start = 1'b0;
    check("t5.start_in_acc_ready", 32'(in_ready), 1);
    in_valid = 1'b1; in_mag = 4'd2;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("t5.gap_no_done", 32'(out_valid), 0);
    in_valid = 1'b1; in_mag = 4'd3;
    @(negedge clk);
    in_valid = 1'b0;
    check("t5.out_valid", 32'(out_valid), 1);
    check("t5.out_mag", 32'(out_mag), 6);
    for (int c = 0; c < 5; c++) begin
      start = 1'b1; len = 4'd2; in_valid = 1'b1; in_mag = 4'd9;
      @(negedge clk);
      check("t5.hold_valid", 32'(out_valid), 1);
      check("t5.hold_mag", 32'(out_mag), 6);
      check("t5.hold_sign", 32'(out_sign), 0);
      check("t5.hold_ready", 32'(in_ready), 0);
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t5.valid_drop", 32'(out_valid), 0);
    check("t5.busy_idle", 32'(busy), 0);
    b_sgn[0] = 0; b_mag[0] = 4;
    do_burst(1, 0, 0, 0, 4, 0, "t5_next");

    // Async reset mid-burst after 2 of 4 beats.
    start = 1'b1; len = 4'd4;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_sign = 1'b0; in_mag = 4'd3;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6.rst_busy", 32'(busy), 0);
    check("t6.rst_in_ready", 32'(in_ready), 0);
    check("t6.rst_out_valid", 32'(out_valid), 0);
    check("t6.rst_out_mag", 32'(out_mag), 0);
    check("t6.rst_out_sat", 32'(out_sat), 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    b_sgn[0] = 0; b_mag[0] = 2;
    do_burst(1, 0, 0, 0, 2, 0, "t6_fresh");

    // Randomized bursts against the reference model.
    for (int r = 0; r < 40; r++) begin
      n = int'($urandom_range(15, 0));
      for (int i = 0; i < 16; i++) begin
        b_sgn[i] = ($urandom_range(3, 0) == 0) ? 1 : int'($urandom_range(1, 0));
        b_mag[i] = (r % 3 == 0) ? int'($urandom_range(15, 12)) : int'($urandom_range(15, 0));
        if (r % 3 == 0) b_sgn[i] = r % 2;
      end
      model(n, es, em, esat);
      do_burst(n, 2, int'($urandom_range(3, 0)), es, em, esat, $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
